// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: FSM state encoding,
// opcode constants, datapath mux codes and the packed control word that the
// output decoder produces.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StMemAddr = 4'd3,
        StMemRd   = 4'd4,
        StMemWb   = 4'd5,
        StMemWr   = 4'd6,
        StRExe    = 4'd7,
        StRWb     = 4'd8,
        StBranch  = 4'd9,
        StJump    = 4'd10,
        StIExe    = 4'd11,
        StIWb     = 4'd12,
        StTrap    = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       trap;
    } ctrl_t;

    // State entered after DECODE for a given opcode; anything unrecognised traps.
    function automatic state_e decode_target(input logic [5:0] op);
        case (op)
            OP_RTYPE:        return StRExe;
            OP_LW, OP_SW:    return StMemAddr;
            OP_BEQ:          return StBranch;
            OP_J:            return StJump;
            OP_ADDI, OP_ORI: return StIExe;
            default:         return StTrap;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control-word decoder.
// Ports:
//   state     : current FSM state
//   op        : opcode captured in DECODE (selects addi/ori ALUOp)
//   mem_ready : memory handshake; gates IRWrite/PCWrite in FETCH only
//   ctrl      : full datapath control word
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  state_e     state,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    logic fetch_done;

    // Without the handshake every fetch completes in one cycle.
    assign fetch_done = mem_ready || !MEM_HANDSHAKE;

    always_comb begin
        ctrl = '0;
        case (state)
            StFetch: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // Load IR and PC+4 only in the cycle the fetch data is present.
                ctrl.ir_write  = fetch_done;
                ctrl.pc_write  = fetch_done;
            end
            StDecode: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            StMemAddr: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            StMemRd: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            StMemWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            StRExe: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            StRWb: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            StIExe: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = (op == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
            end
            StIWb: begin
                ctrl.reg_write = 1'b1;
            end
            StBranch: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            StJump: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            StTrap: begin
                ctrl.trap = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-FSM control unit for the multi-cycle MIPS datapath. Sequences
// FETCH/DECODE/EXECUTE/MEM/WB, stalls memory states on mem_ready, and traps
// (sticky until reset) on illegal opcodes.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   opcode              : IR[31:26], sampled in DECODE
//   zero                : ALU zero flag (branch gating lives in the datapath)
//   mem_ready           : memory completes the current access this cycle
//   PCWrite..PCSource   : datapath enables and mux selects
//   state               : current state encoding
//   trap                : illegal-opcode flag
module multicycle_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W      = 6,
    parameter int unsigned ALUOP_W       = 2,
    parameter bit          MEM_HANDSHAKE = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [1:0]          PCSource,
    output logic [3:0]          state,
    output logic                trap
);

    state_e              state_q;
    logic [OPCODE_W-1:0] op_q;
    logic                mem_go;
    ctrl_t               ctrl;
    logic                unused_zero;

    assign unused_zero = zero;
    assign mem_go      = mem_ready || !MEM_HANDSHAKE;

    // Single-process FSM; the opcode is latched in DECODE so later states see
    // a stable value even if the IR field moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
        end else begin
            case (state_q)
                StIdle:    state_q <= StFetch;
                StFetch:   if (mem_go) state_q <= StDecode;
                StDecode: begin
                    op_q    <= opcode;
                    state_q <= decode_target(opcode);
                end
                StMemAddr: state_q <= (op_q == OP_SW) ? StMemWr : StMemRd;
                StMemRd:   if (mem_go) state_q <= StMemWb;
                StMemWb:   state_q <= StFetch;
                StMemWr:   if (mem_go) state_q <= StFetch;
                StRExe:    state_q <= StRWb;
                StRWb:     state_q <= StFetch;
                StIExe:    state_q <= StIWb;
                StIWb:     state_q <= StFetch;
                StBranch:  state_q <= StFetch;
                StJump:    state_q <= StFetch;
                StTrap:    state_q <= StTrap;
                default:   state_q <= StIdle;
            endcase
        end
    end

    mc_ctrl_outdec #(
        .MEM_HANDSHAKE(MEM_HANDSHAKE)
    ) u_outdec (
        .state    (state_q),
        .op       (op_q),
        .mem_ready(mem_ready),
        .ctrl     (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign trap        = ctrl.trap;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: a driver walks an instruction-level model (each instruction
// is a list of phases, memory phases repeat while mem_ready is low) and queues
// the expected state/control word per cycle; a negedge monitor compares.
module tb_multicycle_control_unit;

    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEM_ADDR = 3, P_MEM_RD = 4;
    localparam int P_MEM_WB = 5, P_MEM_WR = 6, P_R_EXE = 7, P_R_WB = 8, P_BRANCH = 9;
    localparam int P_JUMP = 10, P_I_EXE = 11, P_I_WB = 12, P_TRAP = 13;

    localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
    localparam logic [5:0] T_BEQ = 6'b000100, T_J = 6'b000010, T_ADDI = 6'b001000;
    localparam logic [5:0] T_ORI = 6'b001101, T_BAD = 6'b111111;

    typedef struct {
        int          ph;
        logic [16:0] ctrl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, trap;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic [16:0] act;

    exp_t       sb[$];
    exp_t       mon_e;
    int         plan[$];
    logic [5:0] instr_q[$];
    bit         ready_plan[$];
    logic [5:0] cur_op = '0;
    logic [5:0] legal[6] = '{T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
    int         checks = 0;
    int         errors = 0;

    multicycle_control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSource   (PCSource),
        .state      (state),
        .trap       (trap)
    );

    always #5 clk = ~clk;

    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                  RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, trap};

    // Control word each phase should show, straight from the phase descriptions.
    function automatic logic [16:0] exp_ctrl(int ph, logic [5:0] op, bit rdy);
        logic pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, m2r = 0;
        logic rdst = 0, rw = 0, srca = 0, trp = 0;
        logic [1:0] srcb = 2'b00, aop = 2'b00, pcs = 2'b00;
        case (ph)
            P_FETCH:    begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            P_DECODE:   srcb = 2'b11;
            P_MEM_ADDR: begin srca = 1; srcb = 2'b10; end
            P_MEM_RD:   begin mr = 1; iord = 1; end
            P_MEM_WB:   begin rw = 1; m2r = 1; end
            P_MEM_WR:   begin mw = 1; iord = 1; end
            P_R_EXE:    begin srca = 1; aop = 2'b10; end
            P_R_WB:     begin rw = 1; rdst = 1; end
            P_I_EXE:    begin srca = 1; srcb = 2'b10; aop = (op == T_ORI) ? 2'b11 : 2'b00; end
            P_I_WB:     rw = 1;
            P_BRANCH:   begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            P_JUMP:     begin pcw = 1; pcs = 2'b10; end
            P_TRAP:     trp = 1;
            default:    ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, aop, pcs, trp};
    endfunction

    // Phase list of one instruction (zero wait states).
    task automatic load_plan(input logic [5:0] op);
        plan.delete();
        plan.push_back(P_FETCH);
        plan.push_back(P_DECODE);
        case (op)
            T_LW:   begin plan.push_back(P_MEM_ADDR); plan.push_back(P_MEM_RD);
                          plan.push_back(P_MEM_WB); end
            T_SW:   begin plan.push_back(P_MEM_ADDR); plan.push_back(P_MEM_WR); end
            T_R:    begin plan.push_back(P_R_EXE); plan.push_back(P_R_WB); end
            T_ADDI, T_ORI: begin plan.push_back(P_I_EXE); plan.push_back(P_I_WB); end
            T_BEQ:  plan.push_back(P_BRANCH);
            T_J:    plan.push_back(P_JUMP);
            default: plan.push_back(P_TRAP);
        endcase
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step();
        int   ph;
        bit   rdy;
        exp_t e;
        if (plan.size() == 0) begin
            if (instr_q.size() > 0) cur_op = instr_q.pop_front();
            else cur_op = legal[$urandom_range(0, 5)];
            load_plan(cur_op);
        end
        ph = plan[0];
        // Opcode is only meaningful in DECODE; scramble it elsewhere.
        opcode = (ph == P_DECODE) ? cur_op : 6'($urandom);
        rdy = (ready_plan.size() > 0) ? ready_plan.pop_front() : ($urandom_range(0, 3) != 0);
        mem_ready = rdy;
        zero = 1'($urandom);
        e.ph = ph;
        e.ctrl = exp_ctrl(ph, cur_op, rdy);
        sb.push_back(e);
        if (ph != P_TRAP && !((ph == P_FETCH || ph == P_MEM_RD || ph == P_MEM_WR) && !rdy))
            void'(plan.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        rst_n = 1'b0;
        repeat (n) begin
            opcode = 6'($urandom);
            mem_ready = 1'($urandom);
            e.ph = P_IDLE;
            e.ctrl = '0;
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        plan.delete();
        plan.push_back(P_IDLE);
    endtask

    task automatic run_until(input int ph, input string what);
        int k = 0;
        while (!(plan.size() > 0 && plan[0] == ph) && k < 200) begin
            step();
            k++;
        end
        checks++;
        if (k >= 200) begin
            errors++;
            $display("FAIL %s: phase not reached within 200 cycles, got plan size %0d required phase %0d",
                     what, plan.size(), ph);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (state !== 4'(mon_e.ph) || act !== mon_e.ctrl) begin
                errors++;
                $display("FAIL cycle_ctrl t=%0t: got state %0d ctrl %b, required state %0d ctrl %b",
                         $time, state, act, mon_e.ph, mon_e.ctrl);
            end
            checks++;
            if (MemRead && MemWrite) begin
                errors++;
                $display("FAIL mem_excl t=%0t: got MemRead=1 MemWrite=1, required not both",
                         $time);
            end
        end
    end

    initial begin
        bit [12:0] pat;
        // IDLE, lw with ready high, sw stalling three cycles in MEM_WR.
        pat = 13'b1_11111_111_0001;
        for (int i = 12; i >= 0; i--) ready_plan.push_back(pat[i]);
        instr_q.push_back(T_LW);
        instr_q.push_back(T_SW);
        instr_q.push_back(T_BEQ);
        instr_q.push_back(T_J);
        instr_q.push_back(T_ADDI);
        instr_q.push_back(T_ORI);

        @(posedge clk);
        #1;
        do_reset(3);
        repeat (600) step();

        // Illegal opcode: trap must hold for 20 cycles, then clear on reset.
        instr_q.push_back(T_BAD);
        run_until(P_TRAP, "reach_trap");
        repeat (20) step();
        do_reset(2);

        // Reset asserted asynchronously while in R_EXE.
        instr_q.push_back(T_R);
        run_until(P_R_EXE, "reach_r_exe");
        do_reset(2);
        repeat (60) step();

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Moore-FSM control unit for the multi-cycle MIPS datapath. It is the sequential successor to the single-cycle opcode decoder. It sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction and stalls on a memory ready handshake. It drives every datapath mux/enable and traps on illegal opcodes. It sits between the instruction register opcode field and the shared multi-cycle datapath.

Parameters:
OPCODE_W, 6, opcode field width
ALUOP_W, 2, ALUOp bus width (00 add, 01 sub, 10 funct-decode, 11 or-immediate)
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored, every memory state takes 1 cycle

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  OPCODE_W  IR[31:26], valid from DECODE onward
zero  input  1  ALU zero flag (informational; PCWriteCond gating is done in datapath)
mem_ready  input  1  memory completes the current access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if zero
IorD  output  1  0 = PC addresses memory, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  load instruction register
MemtoReg  output  1  register write data from MDR
RegDst  output  1  0 = rt, 1 = rd
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0 = PC, 1 = A
ALUSrcB  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
ALUOp  output  ALUOP_W  ALU control class
PCSource  output  2  00 ALU, 01 ALUOut, 10 jump target
state  output  4  current state encoding (debug/verification)
trap  output  1  sticky illegal-opcode flag

Behaviour:
- States (4-bit): IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXE=7, R_WB=8, BRANCH=9, JUMP=10, I_EXE=11, I_WB=12, TRAP=13; 14/15 unused -> next state IDLE.
- Reset (async, rst_n=0): state=IDLE, trap=0, every control output 0. All outputs are pure functions of state (Moore); none depend combinationally on inputs.
- IDLE: all outputs 0; next FETCH unconditionally. This guarantees no MemRead during or at release of reset.
- FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCWrite=1, PCSource=00.
  - MEM_HANDSHAKE=1: IRWrite and PCWrite assert only in the cycle mem_ready=1; stay in FETCH while mem_ready=0. (This is the only permitted input dependency of an output; it is documented as a gated Moore output.)
  - mem_ready=1 or MEM_HANDSHAKE=0 -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next on opcode: 000000 -> R_EXE; 100011/101011 -> MEM_ADDR; 000100 -> BRANCH; 000010 -> JUMP; 001000 (addi) -> I_EXE; 001101 (ori) -> I_EXE; any other -> TRAP.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: MemRead=1, IorD=1; hold until mem_ready (when enabled); then MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; -> FETCH.
- MEM_WR: MemWrite=1, IorD=1; hold until mem_ready; -> FETCH.
- R_EXE: ALUSrcA=1, ALUSrcB=00, ALUOp=10; -> R_WB. R_WB: RegWrite=1, RegDst=1, MemtoReg=0; -> FETCH.
- I_EXE: ALUSrcA=1, ALUSrcB=10, ALUOp=00 (addi) or 11 (ori); the opcode is captured into an internal register in DECODE so it stays stable. -> I_WB: RegWrite=1, RegDst=0; -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; -> FETCH.
- JUMP: PCWrite=1, PCSource=10; -> FETCH.
- TRAP: trap=1, all other outputs 0; stays until rst_n asserted.
- Cycle counts with zero wait states: lw 5, sw 4, R/addi/ori 4, beq 3, j 3. Each mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR adds one cycle.
- Reset mid-instruction: immediate return to IDLE; no partial write is held.
- MemRead and MemWrite are never asserted simultaneously in any state.

Decomposition:
- Package mc_ctrl_pkg: state encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI), ALUOp constants, ALUSrcB/PCSource codes.
- One sub-module, mc_ctrl_outdec: combinational state->control-word decoder. The top holds the state register, next-state logic and opcode capture.

Test Plan:
- Reset, release -> IDLE one cycle, then FETCH with MemRead=1; all outputs 0 while rst_n=0.
- lw (100011), mem_ready=1 always -> states 1,2,3,4,5,1; RegWrite=1 and MemtoReg=1 only in MEM_WB; 5 cycles.
- sw with mem_ready low 3 cycles in MEM_WR -> MemWrite held 4 cycles, no RegWrite, then FETCH.
- beq then j -> BRANCH shows PCWriteCond=1, PCSource=01, ALUOp=01; JUMP shows PCWrite=1, PCSource=10; 3 cycles each.
- addi then ori -> I_EXE ALUOp=00 then 11; I_WB RegWrite=1, RegDst=0.
- Opcode 111111 -> TRAP, trap=1 sticky for 20 cycles; rst_n pulse mid-R_EXE -> IDLE, trap=0.
